sqdet_ctrl: RTL and testbench

Controller that streams parallel words into the team's single-bit serial sequence detector and counts its matches. It accepts WIDTH-bit words over a valid/ready handshake, serializes them MSB-first onto the detector's data input, and flushes detector history between non-contiguous words. It accumulates detector hits into a saturating counter and raises a sticky interrupt when a programmed threshold is reached. It sits between a bus-side producer and one detector instance, and owns that instance's reset and data input.

---
 rtl/sqdet_pkg.sv | 16 +
 rtl/sqdet_ctrl_if.sv | 24 ++
 rtl/word_serializer.sv | 45 ++++
 rtl/sqdet_ctrl.sv | 123 ++++++++++++
 tb/tb_sqdet_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sqdet_pkg.sv
// Shared definitions for the serial sequence-detector controller.
package sqdet_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        WAIT  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    // Default widths
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/sqdet_ctrl_if.sv
// Word handshake between a bus-side producer and the detector controller.
interface sqdet_ctrl_if
    import sqdet_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/word_serializer.sv
// Parallel-load shift register with a bit index down-counter; MSB first.
module word_serializer
    import sqdet_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic             bit_out,
    output logic             last
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] shreg;
    logic [IDX_W-1:0] bit_idx;

    // Clear beats load beats shift; once the last bit is out the register
    // has shifted to all-zero, so the serial output idles low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (clr) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (load) begin
            shreg   <= din;
            bit_idx <= IDX_W'(WIDTH - 1);
        end else if (shift) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            if (bit_idx != '0) begin
                bit_idx <= bit_idx - IDX_W'(1);
            end
        end
    end

    assign bit_out = shreg[WIDTH-1];
    assign last    = (bit_idx == '0);

endmodule

// File: rtl/sqdet_ctrl.sv
// Streams words MSB-first into a serial sequence detector, owns its reset,
// and counts its hits into a saturating counter with a sticky threshold irq.
module sqdet_ctrl
    import sqdet_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [CNT_W-1:0] thr,
    sqdet_ctrl_if.slave      bus,
    output logic             det_din,
    output logic             det_rst,
    input  logic             det_hit,
    output logic             busy,
    output logic [CNT_W-1:0] match_cnt,
    output logic             irq
);

    state_t           state;
    logic [CNT_W-1:0] thr_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             in_ready;
    logic             hs;
    logic             last;
    logic             start_acc;
    logic             hit_inc;

    // Handshake and control decode from registered state
    always_comb begin
        in_ready  = (state == WAIT) || ((state == SHIFT) && last);
        hs        = bus.in_valid && in_ready;
        start_acc = (state == IDLE) && start && !stop;
        hit_inc   = (state == SHIFT) && det_hit;
        cnt_inc   = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
        busy      = (state != IDLE);
    end

    assign bus.in_ready = in_ready;

    word_serializer #(
        .WIDTH(WIDTH)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .load   (hs && !stop),
        .shift  (state == SHIFT),
        .clr    (stop),
        .din    (bus.in_data),
        .bit_out(det_din),
        .last   (last)
    );

    // Controller FSM; det_rst is released only while bits are streaming
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            det_rst <= 1'b0;
            thr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    det_rst <= 1'b0;
                    if (start_acc) begin
                        state <= FLUSH;
                        thr_q <= thr;
                    end
                end
                FLUSH: begin
                    det_rst <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (hs) begin
                        state   <= SHIFT;
                        det_rst <= 1'b1;
                    end else begin
                        det_rst <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        if (hs) begin
                            det_rst <= 1'b1;
                        end else begin
                            state   <= WAIT;
                            det_rst <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    det_rst <= 1'b0;
                end
            endcase
            if (stop) begin
                state   <= IDLE;
                det_rst <= 1'b0;
            end
        end
    end

    // Saturating hit counter and sticky threshold interrupt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt <= '0;
            irq       <= 1'b0;
        end else if (clear || start_acc) begin
            match_cnt <= '0;
            irq       <= 1'b0;
        end else if (hit_inc) begin
            match_cnt <= cnt_inc;
            if ((thr_q != '0) && (cnt_inc >= thr_q)) begin
                irq <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sqdet_ctrl.sv
// Directed self-checking bench for sqdet_ctrl; a second instance with a
// 2-bit counter shares all stimulus to exercise saturation.
module tb_sqdet_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       clear;
    logic [7:0] thr;
    logic       det_hit;
    logic       det_din, det_rst, busy, irq;
    logic [7:0] match_cnt;
    logic       det_din2, det_rst2, busy2, irq2;
    logic [1:0] match_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sqdet_ctrl_if #(.WIDTH(8)) bus ();
    sqdet_ctrl_if #(.WIDTH(8)) bus2 ();

    assign bus2.in_valid = bus.in_valid;
    assign bus2.in_data  = bus.in_data;

    sqdet_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .thr(thr), .bus(bus), .det_din(det_din), .det_rst(det_rst),
        .det_hit(det_hit), .busy(busy), .match_cnt(match_cnt), .irq(irq)
    );

    sqdet_ctrl #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .thr(thr[1:0]), .bus(bus2), .det_din(det_din2), .det_rst(det_rst2),
        .det_hit(det_hit), .busy(busy2), .match_cnt(match_cnt2), .irq(irq2)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic go_idle();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    // start pulse, then FLUSH; returns in the first WAIT cycle
    task automatic do_start(input logic [7:0] t);
        thr   = t;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if ({bus.in_ready, det_din, det_rst, busy, irq, match_cnt} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {bus.in_ready, det_din, det_rst, busy, irq, match_cnt});
        end
        checks++;
        if ({busy2, irq2, match_cnt2} !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs2: got %b expected 0", {busy2, irq2, match_cnt2});
        end
        rst = 1'b1;
        step();
        checks++;
        if ({busy, bus.in_ready, det_rst} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 000", {busy, bus.in_ready, det_rst});
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        w = 8'hA5;
        go_idle();
        do_start(8'd0);
        checks++;
        if ({bus.in_ready, det_rst, busy} !== 3'b101) begin
            errors++;
            $display("FAIL wait_state: got %b expected 101", {bus.in_ready, det_rst, busy});
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({det_din, det_rst, bus.in_ready} !== {w[7-i], 1'b1, (i == 7)}) begin
                errors++;
                $display("FAIL single_bit%0d: got din/rst/rdy %b expected %b", i,
                         {det_din, det_rst, bus.in_ready}, {w[7-i], 1'b1, (i == 7)});
            end
            step();
        end
        checks++;
        if ({det_rst, det_din, bus.in_ready, busy} !== 4'b0011) begin
            errors++;
            $display("FAIL single_after: got %b expected 0011",
                     {det_rst, det_din, bus.in_ready, busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hF0;
        step();
        bus.in_data  = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            w = (i < 8) ? 8'hF0 : 8'h0F;
            checks++;
            if ({det_din, det_rst, bus.in_ready} !== {w[7-(i%8)], 1'b1, ((i % 8) == 7)}) begin
                errors++;
                $display("FAIL b2b_bit%0d: got din/rst/rdy %b expected %b", i,
                         {det_din, det_rst, bus.in_ready}, {w[7-(i%8)], 1'b1, ((i % 8) == 7)});
            end
            if (i == 15) bus.in_valid = 1'b0;
            step();
        end
        checks++;
        if ({det_rst, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_after: got %b expected 01", {det_rst, bus.in_ready});
        end
    endtask

    task automatic test_threshold();
        int exp;
        go_idle();
        do_start(8'd3);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        step();
        bus.in_valid = 1'b0;
        exp = 0;
        for (int j = 0; j < 8; j++) begin
            checks++;
            if ({irq, match_cnt} !== {(exp >= 3), 8'(exp)}) begin
                errors++;
                $display("FAIL thr_cycle%0d: got irq=%b cnt=%0d expected irq=%b cnt=%0d",
                         j, irq, match_cnt, (exp >= 3), exp);
            end
            det_hit = (j == 1) || (j == 3) || (j == 5);
            step();
            if (det_hit) exp++;
            det_hit = 1'b0;
        end
        checks++;
        if ({irq, match_cnt, bus.in_ready} !== {1'b1, 8'd3, 1'b1}) begin
            errors++;
            $display("FAIL thr_done: got irq=%b cnt=%0d rdy=%b expected 1 3 1",
                     irq, match_cnt, bus.in_ready);
        end
        det_hit = 1'b1;
        step();
        det_hit = 1'b0;
        checks++;
        if (match_cnt !== 8'd3) begin
            errors++;
            $display("FAIL wait_hit_ignored: got %0d expected 3", match_cnt);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if ({irq, match_cnt} !== 9'h0) begin
            errors++;
            $display("FAIL clear: got irq=%b cnt=%0d expected 0 0", irq, match_cnt);
        end
    endtask

    task automatic test_saturate();
        int n;
        go_idle();
        do_start(8'd0);
        checks++;
        if ({match_cnt, match_cnt2} !== 10'h0) begin
            errors++;
            $display("FAIL sat_start: got %0d/%0d expected 0/0", match_cnt, match_cnt2);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        step();
        bus.in_valid = 1'b0;
        n = 0;
        for (int j = 0; j < 8; j++) begin
            det_hit = (j < 5);
            step();
            det_hit = 1'b0;
            if (j < 5) n++;
            checks++;
            if ({match_cnt, match_cnt2} !== {8'(n), 2'((n > 3) ? 3 : n)}) begin
                errors++;
                $display("FAIL sat_cycle%0d: got %0d/%0d expected %0d/%0d", j,
                         match_cnt, match_cnt2, n, (n > 3) ? 3 : n);
            end
        end
        checks++;
        if ({irq, irq2} !== 2'b00) begin
            errors++;
            $display("FAIL sat_irq_disabled: got %b expected 00", {irq, irq2});
        end
    endtask

    task automatic test_stop();
        go_idle();
        stop  = 1'b1;
        start = 1'b1;
        thr   = 8'd1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        checks++;
        if ({busy, bus.in_ready, match_cnt} !== {1'b0, 1'b0, 8'd5}) begin
            errors++;
            $display("FAIL stop_over_start: got busy=%b rdy=%b cnt=%0d expected 0 0 5",
                     busy, bus.in_ready, match_cnt);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_over_start_late: got busy=%b expected 0", busy);
        end
        do_start(8'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        step();
        bus.in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            det_hit = (j == 1);
            step();
            det_hit = 1'b0;
        end
        checks++;
        if ({det_din, det_rst, match_cnt} !== {1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL stop_pre: got din=%b rst=%b cnt=%0d expected 1 1 1",
                     det_din, det_rst, match_cnt);
        end
        stop    = 1'b1;
        det_hit = 1'b1;
        step();
        stop    = 1'b0;
        det_hit = 1'b0;
        checks++;
        if ({busy, bus.in_ready, det_rst, det_din, match_cnt} !== {4'b0000, 8'd2}) begin
            errors++;
            $display("FAIL stop_mid_word: got %b cnt=%0d expected 0000 cnt=2",
                     {busy, bus.in_ready, det_rst, det_din}, match_cnt);
        end
        for (int j = 0; j < 4; j++) begin
            step();
            checks++;
            if ({det_din, det_rst, busy} !== 3'b000) begin
                errors++;
                $display("FAIL stop_dropped%0d: got %b expected 000", j, {det_din, det_rst, busy});
            end
        end
        thr   = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({busy, match_cnt} !== {1'b1, 8'd0}) begin
            errors++;
            $display("FAIL restart_clears: got busy=%b cnt=%0d expected 1 0", busy, match_cnt);
        end
        step();
    endtask

    task automatic test_reset_mid_shift();
        go_idle();
        do_start(8'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        step();
        bus.in_valid = 1'b0;
        det_hit = 1'b1;
        step();
        det_hit = 1'b0;
        step();
        step();
        checks++;
        if ({irq, det_rst, det_din, match_cnt} !== {3'b111, 8'd1}) begin
            errors++;
            $display("FAIL rst_pre: got %b cnt=%0d expected 111 cnt=1",
                     {irq, det_rst, det_din}, match_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, det_din, det_rst, busy, irq, match_cnt} !== 13'h0) begin
            errors++;
            $display("FAIL rst_async: got %b expected 0",
                     {bus.in_ready, det_din, det_rst, busy, irq, match_cnt});
        end
        checks++;
        if ({det_din2, det_rst2, busy2, irq2, match_cnt2} !== 6'h0) begin
            errors++;
            $display("FAIL rst_async2: got %b expected 0",
                     {det_din2, det_rst2, busy2, irq2, match_cnt2});
        end
        step();
        rst = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            checks++;
            if ({det_din, det_rst, busy, match_cnt} !== 11'h0) begin
                errors++;
                $display("FAIL rst_quiet%0d: got %b expected 0", j,
                         {det_din, det_rst, busy, match_cnt});
            end
        end
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        clear        = 1'b0;
        thr          = 8'd0;
        det_hit      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_threshold();
        test_saturate();
        test_stop();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached without completion, expected finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
